// File: rtl/hrm_pkg.sv
// Shared HRM CPU definitions: instruction geometry and the opcode set.
package hrm_pkg;

    localparam int unsigned INSTR_W = 8;
    localparam int unsigned OPC_MSB = 7;
    localparam int unsigned OPC_LSB = 4;
    localparam int unsigned IND_BIT = 3;
    localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;
    localparam int unsigned OPC_N   = 1 << OPC_W;

    typedef enum logic [OPC_W-1:0] {
        INBOX    = 4'h0,
        OUTBOX   = 4'h1,
        COPYFROM = 4'h2,
        COPYTO   = 4'h3,
        ADD      = 4'h4,
        SUB      = 4'h5,
        BUMPUP   = 4'h6,
        BUMPDN   = 4'h7,
        JUMP     = 4'h8,
        JUMPZ    = 4'h9,
        JUMPN    = 4'hA,
        OPC_RSVB = 4'hB,
        OPC_RSVC = 4'hC,
        OPC_RSVD = 4'hD,
        OPC_RSVE = 4'hE,
        HALT     = 4'hF
    } opcode_e;

    function automatic logic [OPC_N-1:0] opc_onehot(input opcode_e opc);
        opc_onehot = '0;
        opc_onehot[opc] = 1'b1;
    endfunction

endpackage

// File: rtl/ir_decode.sv
// Combinational field decode of the held instruction.
module ir_decode
    import hrm_pkg::*;
(
    input  logic [OPC_MSB:IND_BIT] instr_i,
    output logic [OPC_W-1:0]       opcode_o,
    output logic                   indirect_o,
    output logic [OPC_N-1:0]       op_onehot_o
);

    opcode_e opc;

    always_comb begin
        opc         = opcode_e'(instr_i[OPC_MSB:OPC_LSB]);
        opcode_o    = opc;
        indirect_o  = instr_i[IND_BIT];
        op_onehot_o = opc_onehot(opc);
    end

endmodule

// File: rtl/ir.sv
// Instruction register: captures program-memory data on wIR, decodes the held word.
module ir
    import hrm_pkg::*;
#(
    parameter int unsigned WIDTH       = INSTR_W,
    parameter logic [7:0]  RESET_VALUE = 8'h00
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wIR,
    input  logic        [WIDTH-1:0] nIR,
    output logic signed [WIDTH-1:0] rIR,
    output logic        [3:0]       opcode,
    output logic                    indirect,
    output logic        [15:0]      op_onehot,
    output logic                    ir_valid
);

    localparam logic [WIDTH-1:0] RST_EXT = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] rir_q, rir_d;
    logic             valid_q, valid_d;

    // Hold is the default so an unknown nIR cannot leak in while wIR is low.
    always_comb begin
        rir_d   = rir_q;
        valid_d = valid_q;
        if (wIR) begin
            rir_d   = nIR;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rir_q   <= RST_EXT;
            valid_q <= 1'b0;
        end else begin
            rir_q   <= rir_d;
            valid_q <= valid_d;
        end
    end

    assign rIR      = rir_q;
    assign ir_valid = valid_q;

    ir_decode u_decode (
        .instr_i     (rir_q[OPC_MSB:IND_BIT]),
        .opcode_o    (opcode),
        .indirect_o  (indirect),
        .op_onehot_o (op_onehot)
    );

endmodule

// File: tb/tb_ir.sv
// Self-checking bench for ir: directed vector table, async-reset sequences, random vs. model.
module tb_ir;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              wIR = 1'b0;
    logic        [7:0] nIR = 8'h00;
    logic signed [7:0] rIR;
    logic        [3:0] opcode;
    logic              indirect;
    logic       [15:0] op_onehot;
    logic              ir_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mdl_ir;
    logic       mdl_v;

    ir #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wIR       (wIR),
        .nIR       (nIR),
        .rIR       (rIR),
        .opcode    (opcode),
        .indirect  (indirect),
        .op_onehot (op_onehot),
        .ir_valid  (ir_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [7:0]  n;
        logic [7:0]  e_ir;
        logic        e_v;
        logic [3:0]  e_opc;
        logic        e_ind;
        logic [15:0] e_oh;
    } vec_t;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_ir, input logic e_v,
                             input logic [3:0] e_opc, input logic e_ind, input logic [15:0] e_oh);
        cmp({tag, ".rIR"},       32'($unsigned(rIR)), 32'(e_ir));
        cmp({tag, ".ir_valid"},  32'(ir_valid),       32'(e_v));
        cmp({tag, ".opcode"},    32'(opcode),         32'(e_opc));
        cmp({tag, ".indirect"},  32'(indirect),       32'(e_ind));
        cmp({tag, ".op_onehot"}, 32'(op_onehot),      32'(e_oh));
    endtask

    // Expected decode derived arithmetically from the model's held byte.
    task automatic check_model(input string tag);
        int unsigned opc;
        opc = int'(mdl_ir) / 16;
        check_all(tag, mdl_ir, mdl_v, 4'(opc), mdl_ir[3], 16'(2 ** opc));
    endtask

    task automatic step(input logic w, input logic [7:0] n);
        @(negedge clk);
        wIR = w;
        nIR = n;
        @(posedge clk);
        if (rst_n && w) begin
            mdl_ir = n;
            mdl_v  = 1'b1;
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt[$];
        vt.push_back('{1'b1, 8'h00, 8'h00, 1'b1, 4'h0, 1'b0, 16'h0001});
        vt.push_back('{1'b1, 8'h10, 8'h10, 1'b1, 4'h1, 1'b0, 16'h0002});
        vt.push_back('{1'b0, 8'h20, 8'h10, 1'b1, 4'h1, 1'b0, 16'h0002});
        vt.push_back('{1'b1, 8'h30, 8'h30, 1'b1, 4'h3, 1'b0, 16'h0008});
        vt.push_back('{1'b1, 8'h38, 8'h38, 1'b1, 4'h3, 1'b1, 16'h0008});
        vt.push_back('{1'b1, 8'hA5, 8'hA5, 1'b1, 4'hA, 1'b0, 16'h0400});
        vt.push_back('{1'b1, 8'hFF, 8'hFF, 1'b1, 4'hF, 1'b1, 16'h8000});
        vt.push_back('{1'b0, 8'hxx, 8'hFF, 1'b1, 4'hF, 1'b1, 16'h8000});

        // Async reset with no clock edge.
        #2 rst_n = 1'b0;
        #1;
        check_all("reset", 8'h00, 1'b0, 4'h0, 1'b0, 16'h0001);
        mdl_ir = 8'h00;
        mdl_v  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("post_release", 8'h00, 1'b0, 4'h0, 1'b0, 16'h0001);

        foreach (vt[i]) begin
            step(vt[i].w, vt[i].n);
            check_all($sformatf("vec%0d", i), vt[i].e_ir, vt[i].e_v, vt[i].e_opc,
                      vt[i].e_ind, vt[i].e_oh);
        end

        // Input wiggles between edges must not be captured.
        step(1'b1, 8'h30);
        @(negedge clk);
        wIR = 1'b1; nIR = 8'h77;
        #1 wIR = 1'b0; nIR = 8'h99;
        #1 wIR = 1'b1; nIR = 8'h55;
        #1;
        check_all("between_edges", 8'h30, 1'b1, 4'h3, 1'b0, 16'h0008);
        wIR = 1'b0;
        @(posedge clk);
        #1;
        check_all("hold_after_wiggle", 8'h30, 1'b1, 4'h3, 1'b0, 16'h0008);

        // Reset mid-stream, and reset overriding a load.
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_all("async_mid", 8'h00, 1'b0, 4'h0, 1'b0, 16'h0001);
        wIR = 1'b1; nIR = 8'h55;
        @(posedge clk);
        #1;
        check_all("reset_wins", 8'h00, 1'b0, 4'h0, 1'b0, 16'h0001);
        @(negedge clk);
        rst_n = 1'b1;
        mdl_ir = 8'h00;
        mdl_v  = 1'b0;
        step(1'b1, 8'h40);
        check_all("load_after_rst", 8'h40, 1'b1, 4'h4, 1'b0, 16'h0010);

        // Random traffic with occasional asynchronous reset pulses.
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom));
            check_model($sformatf("rnd%0d", k));
            if ($urandom_range(0, 31) == 0) begin
                @(negedge clk);
                wIR = 1'($urandom_range(0, 1));
                nIR = 8'($urandom);
                #1 rst_n = 1'b0;
                mdl_ir = 8'h00;
                mdl_v  = 1'b0;
                #1;
                check_model($sformatf("rnd_rst%0d", k));
                #1 rst_n = 1'b1;
                @(posedge clk);
                if (wIR) begin
                    mdl_ir = nIR;
                    mdl_v  = 1'b1;
                end
                #1;
                check_model($sformatf("rnd_rel%0d", k));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
